// File: rtl/disp_scan_4dig_pkg.sv
// Shared constants for the 4-digit 7-segment scanner and its bus interface.
package disp_scan_4dig_pkg;
  localparam int DEF_N_DIG = 4;
  localparam int DEF_DIV   = 50000;
  localparam int BCD_W     = 4;
  localparam logic [DEF_N_DIG-1:0] AN_OFF = {DEF_N_DIG{1'b1}};
endpackage

// File: rtl/disp_scan_4dig_if.sv
// Load/display bus between the value producer (master) and the scanner (slave).
interface disp_scan_4dig_if
  import disp_scan_4dig_pkg::*;
  #(parameter int N_DIG = DEF_N_DIG) ();
  logic                     load;
  logic [BCD_W*N_DIG-1:0]   value;
  logic [N_DIG-1:0]         dp_in;
  logic                     blank_lz;
  logic                     ready;
  logic [BCD_W-1:0]         digit_bcd;
  logic                     blank;
  logic [N_DIG-1:0]         an;
  logic                     dp;

  modport master (output load, value, dp_in, blank_lz,
                  input  ready, digit_bcd, blank, an, dp);
  modport slave  (input  load, value, dp_in, blank_lz,
                  output ready, digit_bcd, blank, an, dp);
endinterface

// File: rtl/disp_scan_4dig_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks.
module tick_gen #(
  parameter int DIV = 50000,
  parameter int CW  = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/disp_scan_4dig.sv
// Multiplexed scanner for a common-anode display; new values commit only at
// frame boundaries so a frame never mixes old and new digits.
module disp_scan_4dig
  import disp_scan_4dig_pkg::*;
#(
  parameter int N_DIG = DEF_N_DIG,
  parameter int DIV   = DEF_DIV,
  parameter int CW    = 16
) (
  input logic clk,
  input logic rst,
  disp_scan_4dig_if.slave bus
);
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_DIG - 1);

  logic                   tick, frame_end;
  logic [IW-1:0]          idx;
  logic                   pending;
  logic [BCD_W*N_DIG-1:0] pend_val, disp_val;
  logic [N_DIG-1:0]       pend_dp, disp_dp;
  logic                   upper_zero;
  logic [N_DIG-1:0]       an_n, an_r;
  logic [BCD_W-1:0]       bcd_r;
  logic                   blank_r, dp_r;

  tick_gen #(.DIV(DIV), .CW(CW)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign frame_end = tick & (idx == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      pending  <= 1'b0;
      pend_val <= '0;
      pend_dp  <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
    end else begin
      if (tick) idx <= (idx == LAST) ? '0 : idx + 1'b1;
      // A load landing on frame_end bypasses the pending buffer entirely.
      if (frame_end) begin
        if (bus.load) begin
          disp_val <= bus.value;
          disp_dp  <= bus.dp_in;
        end else if (pending) begin
          disp_val <= pend_val;
          disp_dp  <= pend_dp;
        end
        pending <= 1'b0;
      end else if (bus.load) begin
        pend_val <= bus.value;
        pend_dp  <= bus.dp_in;
        pending  <= 1'b1;
      end
    end
  end

  always_comb begin
    upper_zero = 1'b1;
    an_n       = '1;
    for (int unsigned k = 0; k < N_DIG; k++) begin
      if (k >= 32'(idx) && disp_val[k*BCD_W +: BCD_W] != '0) upper_zero = 1'b0;
      if (k == 32'(idx)) an_n[k] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_r    <= '1;
      bcd_r   <= '0;
      blank_r <= 1'b1;
      dp_r    <= 1'b1;
    end else begin
      an_r    <= an_n;
      bcd_r   <= disp_val[idx*BCD_W +: BCD_W];
      blank_r <= bus.blank_lz & (idx != '0) & upper_zero;
      dp_r    <= ~disp_dp[idx];
    end
  end

  assign bus.ready     = ~pending;
  assign bus.an        = an_r;
  assign bus.digit_bcd = bcd_r;
  assign bus.blank     = blank_r;
  assign bus.dp        = dp_r;
endmodule

// File: tb/tb_disp_scan_4dig.sv
// Bench for disp_scan_4dig with DIV=4: per-cycle reference model plus
// frame-level table checks and hand-written corner sequences.
module tb_disp_scan_4dig;
  import disp_scan_4dig_pkg::*;

  localparam int ND = 4;
  localparam int DV = 4;
  localparam int FR = ND * DV;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  disp_scan_4dig_if #(.N_DIG(ND)) bus ();

  disp_scan_4dig #(.N_DIG(ND), .DIV(DV), .CW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position in the frame is just clocks since reset.
  int          c;
  logic [15:0] m_disp, m_pv;
  logic [3:0]  m_dp, m_pdp;
  logic        m_pend;
  logic [3:0]  e_an, e_bcd;
  logic        e_blank, e_dp, e_ready;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dpi;
    logic        blz;
    logic [3:0]  blk;
    logic [3:0]  dpn;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    int s;
    @(posedge clk);
    if (rst) begin
      c = 0; m_disp = '0; m_dp = '0; m_pv = '0; m_pdp = '0; m_pend = 1'b0;
      e_an = AN_OFF; e_bcd = '0; e_blank = 1'b1; e_dp = 1'b1;
    end else begin
      s       = (c / DV) % ND;
      e_an    = ~(4'b0001 << s);
      e_bcd   = 4'((m_disp >> (4*s)) & 16'hF);
      e_dp    = ~m_dp[s];
      e_blank = bus.blank_lz && (s != 0) && ((m_disp >> (4*s)) == 16'h0);
      if ((c % FR) == FR - 1) begin
        if (bus.load) begin m_disp = bus.value; m_dp = bus.dp_in; end
        else if (m_pend) begin m_disp = m_pv; m_dp = m_pdp; end
        m_pend = 1'b0;
      end else if (bus.load) begin
        m_pv = bus.value; m_pdp = bus.dp_in; m_pend = 1'b1;
      end
      c++;
    end
    e_ready = ~m_pend;
    #1;
    check("model", {21'd0, bus.an, bus.digit_bcd, bus.blank, bus.dp, bus.ready},
                   {21'd0, e_an, e_bcd, e_blank, e_dp, e_ready});
  endtask

  task automatic goto(input int pos);
    for (int i = 0; i < FR + 1 && (c % FR) != pos; i++) step();
    if ((c % FR) != pos) begin
      n_cmp++; n_bad++;
      $display("FAIL align: got %0d want %0d", c % FR, pos);
    end
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] d);
    bus.load = 1'b1; bus.value = v; bus.dp_in = d;
    step();
    bus.load = 1'b0;
  endtask

  initial begin
    tbl[0] = '{16'h1234, 4'b0100, 1'b0, 4'b0000, 4'b1011};
    tbl[1] = '{16'h0070, 4'b0000, 1'b1, 4'b1100, 4'b1111};
    tbl[2] = '{16'h0070, 4'b0000, 1'b0, 4'b0000, 4'b1111};
    tbl[3] = '{16'h0000, 4'b1111, 1'b1, 4'b1110, 4'b0000};
    tbl[4] = '{16'hF0A0, 4'b1001, 1'b1, 4'b0000, 4'b0110};
    tbl[5] = '{16'h0B00, 4'b0000, 1'b1, 4'b1000, 4'b1111};

    rst = 1'b1; bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.blank_lz = 1'b0;
    c = 0; m_pend = 1'b0;

    // Reset state
    step(); step();
    check("rst_out", {bus.an, bus.digit_bcd, bus.blank, bus.dp, bus.ready},
                     {AN_OFF, 4'h0, 1'b1, 1'b1, 1'b1});
    rst = 1'b0;
    step();
    check("first_an", {bus.an, bus.digit_bcd}, {4'b1110, 4'h0});

    // Table-driven frames: load, wait for commit, check every cycle of next frame
    for (int t = 0; t < 6; t++) begin
      goto(3);
      bus.blank_lz = tbl[t].blz;
      load_val(tbl[t].value, tbl[t].dpi);
      if (t == 0) check("ready_low", bus.ready, 1'b0);
      goto(0);
      check("ready_hi", bus.ready, 1'b1);
      for (int j = 0; j < FR; j++) begin
        int s;
        step();
        s = j / DV;
        check($sformatf("tbl%0d_s%0d", t, s),
              {bus.an, bus.digit_bcd, bus.blank, bus.dp},
              {~(4'b0001 << s), tbl[t].value[4*s +: 4], tbl[t].blk[s], tbl[t].dpn[s]});
      end
    end
    bus.blank_lz = 1'b0;

    // Last load in a frame wins; 1111 never appears
    goto(1);
    load_val(16'h1111, 4'b0000);
    step(); step();
    load_val(16'h2222, 4'b0000);
    for (int i = 0; i < FR && (c % FR) != 0; i++) begin
      step();
      if (bus.digit_bcd == 4'h1) check("no_tear", bus.digit_bcd, 4'h2);
    end
    for (int j = 0; j < FR; j++) begin
      step();
      check("last_wins", bus.digit_bcd, 4'h2);
    end

    // Load exactly on frame_end: ready never drops, shown next frame
    goto(FR - 1);
    load_val(16'h5678, 4'b0000);
    check("fe_ready", bus.ready, 1'b1);
    for (int j = 0; j < FR; j++) begin
      logic [15:0] v;
      step();
      v = 16'h5678;
      check("fe_frame", {bus.digit_bcd, bus.ready}, {v[4*(j/DV) +: 4], 1'b1});
    end

    // Reset discards a pending load
    goto(2);
    load_val(16'h9999, 4'b0000);
    check("pend_ready", bus.ready, 1'b0);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_ready", bus.ready, 1'b1);
    for (int j = 0; j < 2*FR; j++) begin
      step();
      check("rst_zero", bus.digit_bcd, 4'h0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bus.load  = ($urandom_range(0, 11) == 0);
      bus.value = 16'($urandom);
      bus.dp_in = 4'($urandom);
      if ($urandom_range(0, 63) == 0) bus.blank_lz = ~bus.blank_lz;
      rst = ($urandom_range(0, 699) == 0);
      step();
    end
    rst = 1'b0; bus.load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
